// File: rtl/param_seq_detector.sv
// Serial detector for a run-time programmable pattern of 1..PAT_W bits.
// Optional saturating match counter enabled by defining SEQ_DET_MATCH_CNT_EN.
module param_seq_detector #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             z,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] HUNT = 2'd2;

  logic [1:0]       state, state_next;
  logic [PAT_W-1:0] hist, hist_next, pat, mask;
  logic [LEN_W-1:0] len, len_clamped, fill, fill_inc, fill_next;
  logic             ovl, sample, match;

  assign len_clamped = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
  assign sample      = x_valid & ~cfg_load;
  assign hist_next   = {hist[PAT_W-2:0], x};
  assign fill_inc    = (fill >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : fill + LEN_W'(1);

  // Only the newest len bits of the history take part in the compare.
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
    assign mask[gi] = (LEN_W'(gi) < len);
  end

  assign match = (state != IDLE) & sample & (fill_inc >= len) &
                 ((hist_next & mask) == (pat & mask));

  always_comb begin
    state_next = state;
    fill_next  = fill;
    if (cfg_load) begin
      fill_next  = '0;
      state_next = (len_clamped == '0) ? IDLE : FILL;
    end else if (x_valid) begin
      fill_next = fill_inc;
      case (state)
        FILL: begin
          if (match) begin
            if (ovl) state_next = HUNT;
            else     fill_next  = '0;
          end else if (fill_inc >= len) begin
            state_next = HUNT;
          end
        end
        HUNT: begin
          // Non-overlap restarts the fill count but keeps the history bits.
          if (match && !ovl) begin
            state_next = FILL;
            fill_next  = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hist  <= '0;
      fill  <= '0;
      pat   <= '0;
      len   <= '0;
      ovl   <= 1'b0;
      z     <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      fill  <= fill_next;
      z     <= match;
      armed <= (state_next == HUNT);
      if (cfg_load) begin
        pat  <= cfg_pattern;
        len  <= len_clamped;
        ovl  <= cfg_overlap;
        hist <= '0;
      end else if (x_valid) begin
        hist <= hist_next;
      end
    end
  end

  logic unused_hist_msb;
  assign unused_hist_msb = hist[PAT_W-1];

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (match && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match_cnt = cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule
